// File: rtl/step_sequencer.sv
// step_sequencer: trapezoidal-profile STEP/DIR generator for an external stepper driver
module step_sequencer #(
  parameter int PULSE_W   = 100,
  parameter int DIR_SETUP = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_steps,
  input  logic        cmd_dir,
  input  logic [31:0] cmd_start_period,
  input  logic [31:0] cmd_min_period,
  input  logic [31:0] cmd_accel,
  input  logic        abort,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] steps_left,
  output logic [31:0] cur_period
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT, DONE} state_t;
  localparam logic [31:0] PW      = 32'(PULSE_W);
  localparam logic [31:0] PMIN    = 32'(PULSE_W + 1);
  localparam logic [31:0] DS_LAST = 32'(DIR_SETUP - 1);
  state_t      state_q, state_d;
  logic [31:0] cnt, ps_q, pm_q, accel_q, ramp_cnt;
  logic        abort_pend;
  logic        accept, rise, decel, speed_up;
  logic [31:0] ps_c, pm_w, pm_c, r, dec_p, acc_p, nxt_period, nxt_ramp;
  logic [32:0] sum;
  assign cmd_ready = state_q == IDLE;
  assign busy      = !cmd_ready;
  assign step_out  = state_q == PULSE;
  assign done      = state_q == DONE;
  assign accept    = cmd_valid && cmd_ready;
  assign rise      = state_d == PULSE && state_q != PULSE;
  // Command period clamping and the per-step ramp update evaluated at each STEP rise
  always_comb begin
    ps_c       = cmd_start_period > PW ? cmd_start_period : PMIN;
    pm_w       = cmd_min_period > PW ? cmd_min_period : PMIN;
    pm_c       = pm_w > ps_c ? ps_c : pm_w;
    r          = steps_left - 32'd1;
    sum        = {1'b0, cur_period} + {1'b0, accel_q};
    dec_p      = sum > {1'b0, ps_q} ? ps_q : sum[31:0];
    acc_p      = ({1'b0, accel_q} + {1'b0, pm_q}) >= {1'b0, cur_period} ? pm_q : cur_period - accel_q;
    decel      = r <= ramp_cnt;
    speed_up   = cur_period > pm_q;
    nxt_period = decel ? dec_p : speed_up ? acc_p : cur_period;
    nxt_ramp   = decel ? (ramp_cnt == 32'd0 ? 32'd0 : ramp_cnt - 32'd1) : speed_up ? ramp_cnt + 32'd1 : ramp_cnt;
  end
  // Next-state logic; abort wins over a STEP rise scheduled on the same edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SETUP : IDLE;
      SETUP:   state_d = (abort || steps_left == 32'd0) ? DONE : cnt == DS_LAST ? PULSE : SETUP;
      PULSE:   state_d = cnt != PW ? PULSE : (abort || abort_pend || steps_left == 32'd0) ? DONE : WAIT;
      WAIT:    state_d = abort ? DONE : cnt == cur_period ? PULSE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State, interval counter, command latches and profile registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt        <= '0;
      dir_out    <= 1'b0;
      steps_left <= '0;
      cur_period <= '0;
      ps_q       <= '0;
      pm_q       <= '0;
      accel_q    <= '0;
      ramp_cnt   <= '0;
      abort_pend <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt     <= accept ? 32'd0 : rise ? 32'd1 : cnt + 32'd1;
      if (accept) begin
        dir_out    <= cmd_dir;
        steps_left <= cmd_steps;
        cur_period <= ps_c;
        ps_q       <= ps_c;
        pm_q       <= pm_c;
        accel_q    <= cmd_accel;
        ramp_cnt   <= '0;
      end else if (rise) begin
        steps_left <= r;
        cur_period <= nxt_period;
        ramp_cnt   <= nxt_ramp;
      end
      abort_pend <= accept ? 1'b0 : (state_q == PULSE && abort) ? 1'b1 : abort_pend;
      aborted    <= accept ? 1'b0 : (state_d == DONE && state_q != DONE && (abort || abort_pend)) ? 1'b1 : aborted;
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed moves checked every cycle against a timeline model of the move
module tb_step_sequencer;
  localparam int PW = 4;
  localparam int DS = 2;
  logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
  logic [31:0] cmd_steps = '0, cmd_start_period = '0, cmd_min_period = '0, cmd_accel = '0;
  logic        cmd_ready, step_out, dir_out, busy, done, aborted;
  logic [31:0] steps_left, cur_period;
  int          cyc = 0, e_cyc = 0, checks = 0, errors = 0;
  bit          have_move = 0, chk_en = 1, m_ab = 0, m_dir = 0;
  int          m_rise[$];
  longint      m_per[$];
  int          m_done = 0;
  longint      m_steps = 0, m_ps = 0;

  step_sequencer #(.PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_start_period(cmd_start_period),
    .cmd_min_period(cmd_min_period), .cmd_accel(cmd_accel), .abort(abort),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left), .cur_period(cur_period)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d expected %0d", name, cyc - e_cyc, act, exp);
    end
  endtask

  // Timeline of one move: STEP rise offsets from the accept edge, interval after each rise, end edge
  task automatic load_model(longint steps, longint start, longint mn, longint acc, int ab, bit dir);
    longint ps, pm, cur, ramp, r;
    int     rr, pf;
    ps = start > PW ? start : PW + 1;
    pm = mn > PW ? mn : PW + 1;
    if (pm > ps) pm = ps;
    m_rise.delete();
    m_per.delete();
    m_ab = 0; m_steps = steps; m_ps = ps; m_dir = dir;
    if (steps == 0) begin m_done = 1; return; end
    cur = ps; ramp = 0; rr = DS; pf = 0;
    for (longint i = 0; i < steps; i++) begin
      if (ab > pf && ab <= rr) begin m_done = ab; m_ab = 1; return; end
      m_rise.push_back(rr);
      r = steps - 1 - i;
      if (r <= ramp) begin
        cur = cur + acc > ps ? ps : cur + acc;
        ramp = ramp > 0 ? ramp - 1 : 0;
      end else if (cur > pm) begin
        cur = cur - acc < pm ? pm : cur - acc;
        ramp++;
      end
      m_per.push_back(cur);
      if (ab > rr && ab <= rr + PW) begin m_done = rr + PW; m_ab = 1; return; end
      if (r == 0) begin m_done = rr + PW; return; end
      pf = rr + PW;
      rr = rr + int'(cur);
    end
  endtask

  task automatic start_move(longint steps, bit dir, longint start, longint mn, longint acc, int ab);
    cmd_steps = 32'(steps); cmd_dir = dir; cmd_start_period = 32'(start);
    cmd_min_period = 32'(mn); cmd_accel = 32'(acc); cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e_cyc = cyc;
    load_model(steps, start, mn, acc, ab, dir);
    have_move = 1;
  endtask

  task automatic wait_t(int k);
    int g = 0;
    do begin @(negedge clk); g++; end while (cyc - e_cyc < k && g < 5000);
    if (g >= 5000) chk("timeout", cyc - e_cyc, k);
  endtask

  // Every-cycle comparison of all outputs against the model timeline
  always @(negedge clk) begin : cmp
    int t, nrise;
    bit e_step;
    longint e_per;
    if (chk_en) begin
      if (!have_move) begin
        chk("rst_ready", cmd_ready, 1); chk("rst_busy", busy, 0); chk("rst_step", step_out, 0);
        chk("rst_dir", dir_out, 0); chk("rst_done", done, 0); chk("rst_aborted", aborted, 0);
        chk("rst_left", steps_left, 0); chk("rst_period", cur_period, 0);
      end else begin
        t = cyc - e_cyc; nrise = 0; e_step = 0; e_per = m_ps;
        foreach (m_rise[k]) if (m_rise[k] <= t) begin
          nrise++;
          e_per = m_per[k];
          if (t < m_rise[k] + PW) e_step = 1;
        end
        chk("ready", cmd_ready, t > m_done);
        chk("busy", busy, t <= m_done);
        chk("step", step_out, e_step);
        chk("done", done, t == m_done);
        chk("aborted", aborted, t >= m_done ? m_ab : 0);
        chk("dir", dir_out, m_dir);
        chk("left", steps_left, m_steps - nrise);
        chk("period", cur_period, e_per);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // constant speed, 3 steps
    start_move(3, 1, 10, 10, 0, 0);
    chk("t1_nrise", m_rise.size(), 3); chk("t1_r0", m_rise[0], 2);
    chk("t1_r1", m_rise[1], 12); chk("t1_r2", m_rise[2], 22); chk("t1_done", m_done, 26);
    wait_t(m_done + 1);
    // zero steps, back-to-back
    start_move(0, 0, 50, 20, 3, 0);
    chk("t3_done", m_done, 1); chk("t3_nrise", m_rise.size(), 0);
    wait_t(m_done + 1);
    // trapezoid ramp, with a command offered while busy
    start_move(5, 1, 20, 10, 5, 0);
    chk("t2_i0", m_rise[1] - m_rise[0], 15); chk("t2_i1", m_rise[2] - m_rise[1], 10);
    chk("t2_i2", m_rise[3] - m_rise[2], 15); chk("t2_i3", m_rise[4] - m_rise[3], 20);
    chk("t2_last", m_per[4], 20);
    wait_t(20);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 32'd7;
    repeat (3) @(negedge clk);
    cmd_valid = 1'b0;
    wait_t(m_done + 1);
    chk("t2_curp", cur_period, 20); chk("t2_ab", aborted, 0);
    // clamping to PULSE_W+1
    start_move(3, 0, 2, 1, 7, 0);
    chk("t4_i0", m_rise[1] - m_rise[0], 5); chk("t4_i1", m_rise[2] - m_rise[1], 5);
    wait_t(m_done + 1);
    // abort during the second pulse
    start_move(10, 0, 10, 10, 0, 14);
    chk("ta_done", m_done, 16); chk("ta_ab", m_ab, 1);
    wait_t(13);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_t(m_done + 1);
    chk("ta_left", steps_left, 8); chk("ta_aborted", aborted, 1);
    // abort in WAIT
    start_move(10, 1, 10, 10, 0, 8);
    chk("tb_done", m_done, 8);
    wait_t(7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_t(m_done + 1);
    chk("tb_left", steps_left, 9);
    // asynchronous reset mid-pulse
    start_move(10, 1, 10, 10, 0, 0);
    wait_t(13);
    chk_en = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_step", step_out, 0); chk("ar_ready", cmd_ready, 1); chk("ar_busy", busy, 0);
    chk("ar_dir", dir_out, 0); chk("ar_done", done, 0); chk("ar_left", steps_left, 0);
    chk("ar_period", cur_period, 0); chk("ar_aborted", aborted, 0);
    @(negedge clk);
    chk("ar_step2", step_out, 0); chk("ar_done2", done, 0);
    #1 rst_n = 1'b1;
    have_move = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);
    // recovery move
    start_move(2, 1, 6, 6, 0, 0);
    chk("tr_done", m_done, 12);
    wait_t(m_done + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
